pirad_stream_buffer_in: RTL

- Capture-side counterpart of the stream buffer output block: an AXI4-Stream slave receives samples into an on-chip buffer.
- Software arms a capture over AXI4-Lite and reads the captured words back over the same AXI4-Lite slave.
- Sits between a sample source (ADC/DSP chain) and the PS AXI interconnect.
- One clock domain; the stream side and the register side share ACLK.

---
 rtl/pirad_stream_buffer_in_pkg.sv | 33 +++
 rtl/pirad_sdp_ram.sv | 35 +++
 rtl/pirad_stream_buffer_in.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pirad_stream_buffer_in_pkg.sv
// pirad_stream_buffer_in_pkg
// Shared definitions for the capture-side stream buffer: register offsets,
// CTRL bit positions, the capture state encoding and AXI response codes.
package pirad_stream_buffer_in_pkg;

  // Byte offsets in the AXI4-Lite window (word aligned)
  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_LEN    = 32'h0000_0008;
  localparam logic [31:0] REG_COUNT  = 32'h0000_000C;
  localparam logic [31:0] BUF_BASE   = 32'h0000_1000;

  // CTRL bit indices; ARM, ABORT and CLR_DONE act only on the write itself
  localparam int CTRL_ARM        = 0;
  localparam int CTRL_ABORT      = 1;
  localparam int CTRL_STOP_TLAST = 2;
  localparam int CTRL_CLR_DONE   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } capture_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Drop the byte-lane bits so every access is treated as a full word
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pirad_sdp_ram.sv
// pirad_sdp_ram
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
// Ports:
//   i_clk                       clock
//   i_wr_en/i_wr_addr/i_wr_data write port
//   i_rd_en/i_rd_addr           read request
//   o_rd_data                   read data, valid the cycle after i_rd_en
module pirad_sdp_ram
  import pirad_stream_buffer_in_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pirad_stream_buffer_in.sv
// pirad_stream_buffer_in
// Captures an AXI4-Stream into an on-chip buffer; software arms the capture
// and reads the buffer back through an AXI4-Lite slave. Single clock (ACLK).
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   s_axis_*                stream slave (tdata/tvalid/tready/tlast)
//   s_axil_aw*/w*/b*        AXI4-Lite write channels (wstrb has no effect)
//   s_axil_ar*/r*           AXI4-Lite read channels (one read in flight)
//   irq                     high while a finished capture waits in DONE
module pirad_stream_buffer_in #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 1024,
  parameter int AXIL_ADDR_WIDTH = 14
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [31:0]                s_axil_wdata,
  input  logic [3:0]                 s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [31:0]                s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       irq
);
  import pirad_stream_buffer_in_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;  // word counts run 0..DEPTH inclusive
  localparam logic [31:0]   BUF_END = BUF_BASE + 32'(4 * DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  capture_state_t r_state, w_state_next;
  logic [CW-1:0]  r_wr_idx, r_len, r_len_cap, w_len_val;
  logic           r_stop_tlast, r_tlast_seen;
  logic           r_awready, r_bvalid;
  logic [1:0]     r_bresp;
  logic           r_arready, r_rd_p1, r_rvalid, r_rd_is_buf;
  logic [31:0]    r_rd_addr, r_rdata, w_rd_value, w_wr_addr, w_ar_addr;
  logic [1:0]     r_rresp;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic w_wr_fire, w_wr_is_buf, w_ctrl_wr, w_len_wr, w_arm, w_abort, w_clr;
  logic w_beat, w_term, w_start, w_ar_fire, w_r_fire, w_ar_is_buf;
  logic w_tready, w_irq;
  logic w_unused_wstrb;

  // Every write is a full-word write; byte strobes are accepted and ignored
  assign w_unused_wstrb = ^s_axil_wstrb;

  // ---------------- write decode ----------------
  assign w_wr_fire   = r_awready & s_axil_awvalid & s_axil_wvalid;
  assign w_wr_addr   = word_align(32'(s_axil_awaddr));
  assign w_wr_is_buf = (w_wr_addr >= BUF_BASE) && (w_wr_addr < BUF_END);
  assign w_ctrl_wr   = w_wr_fire && (w_wr_addr == REG_CTRL);
  assign w_len_wr    = w_wr_fire && (w_wr_addr == REG_LEN);
  assign w_arm       = w_ctrl_wr & s_axil_wdata[CTRL_ARM];
  assign w_abort     = w_ctrl_wr & s_axil_wdata[CTRL_ABORT];
  assign w_clr       = w_ctrl_wr & s_axil_wdata[CTRL_CLR_DONE];
  assign w_len_val   = (s_axil_wdata == 32'd0 || s_axil_wdata > 32'(DEPTH)) ?
                       DEPTH_C : s_axil_wdata[CW-1:0];

  // ---------------- capture control ----------------
  assign w_beat  = (r_state == CAPTURE) & s_axis_tvalid;
  // Length compare uses the value latched at ARM so LEN writes mid-capture wait
  assign w_term  = w_beat & ((r_wr_idx == r_len_cap - CW'(1)) |
                             (r_stop_tlast & s_axis_tlast));
  assign w_start = w_arm & ~w_abort & (r_state != CAPTURE);

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_arm) w_state_next = CAPTURE;
        CAPTURE: if (w_term) w_state_next = DONE;
        DONE: begin
          if (w_arm)      w_state_next = CAPTURE;
          else if (w_clr) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_tready = (r_state == CAPTURE);
    w_irq    = (r_state == DONE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_idx     <= '0;
      r_len        <= DEPTH_C;
      r_len_cap    <= DEPTH_C;
      r_stop_tlast <= 1'b0;
      r_tlast_seen <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_idx     <= '0;
        r_len_cap    <= r_len;
        r_tlast_seen <= 1'b0;
      end else if (w_beat) begin
        r_wr_idx <= r_wr_idx + CW'(1);
        if (s_axis_tlast) r_tlast_seen <= 1'b1;
      end
      // Leaving a capture by ABORT or CLR_DONE forgets the tlast flag
      if (w_abort || (w_clr && r_state == DONE)) r_tlast_seen <= 1'b0;
      if (w_ctrl_wr) r_stop_tlast <= s_axil_wdata[CTRL_STOP_TLAST];
      if (w_len_wr)  r_len <= w_len_val;
    end
  end

  // ---------------- write response ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      // One-cycle pulse; the !r_awready term prevents a second pulse
      r_awready <= ~r_awready & ~r_bvalid & s_axil_awvalid & s_axil_wvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_is_buf ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- read path ----------------
  assign w_ar_fire   = r_arready & s_axil_arvalid;
  assign w_r_fire    = r_rvalid & s_axil_rready;
  assign w_ar_addr   = word_align(32'(s_axil_araddr));
  assign w_ar_is_buf = (w_ar_addr >= BUF_BASE) && (w_ar_addr < BUF_END);

  pirad_sdp_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .i_clk     (ACLK),
    .i_wr_en   (w_beat),
    .i_wr_addr (r_wr_idx[AW-1:0]),
    .i_wr_data (s_axis_tdata),
    .i_rd_en   (w_ar_fire & w_ar_is_buf),
    .i_rd_addr (AW'((w_ar_addr - BUF_BASE) >> 2)),
    .o_rd_data (w_ram_q)
  );

  always_comb begin
    w_rd_value = '0;
    if (r_rd_is_buf) begin
      w_rd_value = 32'(w_ram_q);
    end else begin
      case (r_rd_addr)
        REG_CTRL:   w_rd_value[CTRL_STOP_TLAST] = r_stop_tlast;
        REG_STATUS: w_rd_value[2:0] = {r_tlast_seen, r_state == DONE,
                                       r_state == CAPTURE};
        REG_LEN:    w_rd_value = 32'(r_len);
        REG_COUNT:  w_rd_value = 32'(r_wr_idx);
        default:    w_rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready   <= 1'b0;
      r_rd_p1     <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_is_buf <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
    end else begin
      // Ready again only once nothing is in flight after this edge
      r_arready <= ~(w_ar_fire | r_rd_p1 | (r_rvalid & ~s_axil_rready));
      r_rd_p1   <= w_ar_fire;
      if (w_ar_fire) begin
        r_rd_addr   <= w_ar_addr;
        r_rd_is_buf <= w_ar_is_buf;
      end
      if (r_rd_p1) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_value;
        r_rresp  <= RESP_OKAY;
      end else if (w_r_fire) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axis_tready  = w_tready;
  assign irq            = w_irq;
  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_awready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;

endmodule
